// File: rtl/rioencoder_turns_pkg.sv
// rioencoder_turns shared types
// FSM states, fault codes, sign-extension helper
package rioencoder_turns_pkg;

  typedef enum logic [1:0] {
    INIT_RST,
    INIT_RE,
    TRACK,
    FAULT
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_JUMP    = 2'd2;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/rioencoder_turns_vel.sv
// rioencoder_turns windowed velocity
// Free-running window, snapshot and subtractor
module rioencoder_turns_vel
  import rioencoder_turns_pkg::*;
#(
  parameter int VEL_PERIOD = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] position,
  input  logic        tracking,
  output logic [31:0] velocity
);

  localparam int CW = $clog2(VEL_PERIOD);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_snap;
  logic [31:0]   r_vel;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(VEL_PERIOD - 1));

  // Window counter always runs; snapshot tracks position outside TRACK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_vel  <= '0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
      if (!tracking) begin
        r_vel  <= '0;
        r_snap <= position;
      end else if (w_tc) begin
        r_vel  <= position - r_snap;
        r_snap <= position;
      end
    end
  end

  assign velocity = tracking ? r_vel : '0;

endmodule

// File: rtl/rioencoder_turns.sv
// rioencoder_turns multi-turn tracker
// Unwraps 16-bit angles, watchdog, jump check
module rioencoder_turns
  import rioencoder_turns_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int MAX_STEP       = 16384,
  parameter int VEL_PERIOD     = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] angle,
  input  logic        angle_valid,
  input  logic        fault_clear,
  output logic [31:0] position,
  output logic [31:0] velocity,
  output logic        valid,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [31:0]        r_pos;
  logic [31:0]        w_pos_nx;
  logic [1:0]         r_fc;
  logic [1:0]         w_fc_nx;
  logic [WW-1:0]      r_wd;
  logic [WW-1:0]      w_wd_nx;
  logic [15:0]        w_d;
  logic signed [31:0] w_d_s;
  logic               w_jump;
  logic               w_expired;
  logic               w_tracking;

  // Low half of position doubles as the previous angle
  assign w_d       = angle - r_pos[15:0];
  assign w_d_s     = signed'(sext16(w_d));
  assign w_jump    = (w_d_s > MAX_STEP) ||
                     (w_d_s < -MAX_STEP);
  assign w_expired = (r_wd == WW'(TIMEOUT_CYCLES));

  // Next state, position and fault code
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_fc_nx    = r_fc;
    unique case (r_state)
      INIT_RST: begin
        if (angle_valid) begin
          w_pos_nx   = {16'h0, angle};
          w_state_nx = TRACK;
        end
      end
      TRACK: begin
        if (angle_valid) begin
          if (w_jump) begin
            w_fc_nx    = FC_JUMP;
            w_state_nx = FAULT;
          end else begin
            w_pos_nx = r_pos + sext16(w_d);
          end
        end else if (w_expired) begin
          w_fc_nx    = FC_TIMEOUT;
          w_state_nx = FAULT;
        end
      end
      FAULT: begin
        if (fault_clear) begin
          w_fc_nx    = FC_NONE;
          w_state_nx = INIT_RE;
        end
      end
      INIT_RE: begin
        if (angle_valid) begin
          w_pos_nx   = r_pos + sext16(w_d);
          w_state_nx = TRACK;
        end
      end
      default: w_state_nx = INIT_RST;
    endcase
  end

  // Watchdog restarts on samples and state changes, saturates
  always_comb begin
    w_wd_nx = r_wd;
    if (angle_valid || (w_state_nx != r_state))
      w_wd_nx = '0;
    else if (!w_expired)
      w_wd_nx = r_wd + WW'(1);
  end

  // State, position, fault code and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_RST;
      r_pos   <= '0;
      r_fc    <= FC_NONE;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pos   <= w_pos_nx;
      r_fc    <= w_fc_nx;
      r_wd    <= w_wd_nx;
    end
  end

  assign w_tracking = (r_state == TRACK);

  rioencoder_turns_vel #(
    .VEL_PERIOD(VEL_PERIOD)
  ) u_vel (
    .clk      (clk),
    .rst      (rst),
    .position (r_pos),
    .tracking (w_tracking),
    .velocity (velocity)
  );

  assign position   = r_pos;
  assign valid      = w_tracking;
  assign fault      = (r_state == FAULT);
  assign fault_code = r_fc;

endmodule

// File: tb/tb_rioencoder_turns.sv
// rioencoder_turns testbench
// Scenario tasks against a behavioural model
module tb_rioencoder_turns;

  localparam int T  = 300;
  localparam int MS = 16384;
  localparam int VP = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] angle = '0;
  logic        angle_valid = 1'b0;
  logic        fault_clear = 1'b0;
  logic [31:0] position;
  logic [31:0] velocity;
  logic        valid;
  logic        fault;
  logic [1:0]  fault_code;

  int errors = 0;
  int checks = 0;

  // model: 0 init-after-reset, 1 init-after-fault, 2 tracking, 3 fault
  int          m_mode;
  logic [31:0] m_pos;
  logic [31:0] m_snap;
  logic [31:0] m_vreg;
  logic [1:0]  m_fc;
  int          m_idle;
  int          m_phase;

  rioencoder_turns #(
    .TIMEOUT_CYCLES(T),
    .MAX_STEP(MS),
    .VEL_PERIOD(VP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .angle       (angle),
    .angle_valid (angle_valid),
    .fault_clear (fault_clear),
    .position    (position),
    .velocity    (velocity),
    .valid       (valid),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "timeout");
  end

  function automatic int sdelta(
    input logic [15:0] a,
    input logic [15:0] b
  );
    int x;
    x = int'({16'h0, a}) - int'({16'h0, b});
    if (x > 32767) x -= 65536;
    if (x < -32768) x += 65536;
    return x;
  endfunction

  function automatic logic [31:0] m_vel_out();
    return (m_mode == 2) ? m_vreg : 32'h0;
  endfunction

  function automatic logic [36:0] m_outs();
    return {m_pos, m_vel_out() == 32'h0 ? 1'b0 : 1'b0,
            (m_mode == 2), (m_mode == 3), m_fc, 1'b0};
  endfunction

  task automatic model_edge(
    input logic [15:0] a,
    input logic        av,
    input logic        fc,
    input logic        r
  );
    int prev;
    int d;
    if (r) begin
      m_mode = 0; m_pos = 0; m_snap = 0; m_vreg = 0;
      m_fc = 0; m_idle = 0; m_phase = 0;
      return;
    end
    prev = m_mode;
    if (m_mode == 2) begin
      if (m_phase == VP - 1) begin
        m_vreg = m_pos - m_snap;
        m_snap = m_pos;
      end
    end else begin
      m_vreg = 0;
      m_snap = m_pos;
    end
    m_phase = (m_phase + 1) % VP;
    d = sdelta(a, m_pos[15:0]);
    case (m_mode)
      0: if (av) begin
        m_pos = {16'h0, a};
        m_mode = 2;
      end
      2: if (av) begin
        if (d > MS || d < -MS) begin
          m_fc = 2; m_mode = 3;
        end else begin
          m_pos = m_pos + 32'(d);
        end
      end else if (m_idle >= T) begin
        m_fc = 1; m_mode = 3;
      end
      3: if (fc) begin
        m_fc = 0; m_mode = 1;
      end
      default: if (av) begin
        m_pos = m_pos + 32'(d);
        m_mode = 2;
      end
    endcase
    if (av || m_mode != prev) m_idle = 0;
    else if (m_idle < T) m_idle++;
  endtask

  task automatic tick(
    input logic [15:0] a,
    input logic        av,
    input logic        fc,
    input logic        r
  );
    angle = a;
    angle_valid = av;
    fault_clear = fc;
    rst = r;
    model_edge(a, av, fc, r);
    @(posedge clk);
    #1;
    angle_valid = 1'b0;
    fault_clear = 1'b0;
    rst = 1'b0;
  endtask

  task automatic samp(input logic [15:0] a);
    tick(a, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(angle, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({position, velocity, valid, fault, fault_code} !== 68'h0) begin
      errors++;
      $display("FAIL reset pos=%h vel=%h v=%b f=%b fc=%0d exp all 0",
               position, velocity, valid, fault, fault_code);
    end
    samp(16'h1234);
    checks++;
    if (position !== 32'h0000_1234 || valid !== 1'b1) begin
      errors++;
      $display("FAIL first_sample pos=%h v=%b exp 00001234 v=1",
               position, valid);
    end
  endtask

  task automatic test_wrap();
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    samp(16'hFFF0);
    samp(16'h0010);
    checks++;
    if (position !== 32'h0001_0010) begin
      errors++;
      $display("FAIL wrap_fwd pos=%h exp 00010010", position);
    end
    samp(16'hFFF0);
    checks++;
    if (position !== 32'h0000_FFF0) begin
      errors++;
      $display("FAIL wrap_back pos=%h exp 0000fff0", position);
    end
  endtask

  task automatic test_jump();
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    samp(16'h1000);
    tick(16'h1000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || fault_code !== 2'd0) begin
      errors++;
      $display("FAIL clear_in_track v=%b fc=%0d exp v=1 fc=0",
               valid, fault_code);
    end
    samp(16'h6000);
    checks++;
    if ({fault, valid, fault_code, position} !==
        {1'b1, 1'b0, 2'd2, 32'h0000_1000}) begin
      errors++;
      $display("FAIL jump f=%b v=%b fc=%0d pos=%h exp 1 0 2 00001000",
               fault, valid, fault_code, position);
    end
    tick(16'h7000, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({fault, valid, fault_code, position} !==
        {1'b0, 1'b0, 2'd0, 32'h0000_1000}) begin
      errors++;
      $display("FAIL clear_w_sample f=%b v=%b fc=%0d pos=%h exp 0 0 0 00001000",
               fault, valid, fault_code, position);
    end
    samp(16'h6000);
    checks++;
    if (position !== 32'h0000_6000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reanchor pos=%h v=%b exp 00006000 v=1",
               position, valid);
    end
    samp(16'hA000);
    checks++;
    if (position !== 32'h0000_A000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL step_max pos=%h v=%b exp 0000a000 v=1",
               position, valid);
    end
    samp(16'h2000);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2 ||
        position !== 32'h0000_A000) begin
      errors++;
      $display("FAIL jump_neg_half f=%b fc=%0d pos=%h exp 1 2 0000a000",
               fault, fault_code, position);
    end
    tick(16'h2000, 1'b0, 1'b1, 1'b0);
    samp(16'h2000);
    checks++;
    if (position !== 32'h0000_2000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reanchor_big pos=%h v=%b exp 00002000 v=1",
               position, valid);
    end
    samp(16'hDFFF);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL jump_over_max f=%b fc=%0d exp 1 2",
               fault, fault_code);
    end
  endtask

  task automatic test_timeout();
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    samp(16'h0100);
    idle(T);
    checks++;
    if (fault !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early f=%b v=%b exp 0 1", fault, valid);
    end
    idle(1);
    checks++;
    if ({fault, fault_code, velocity, position} !==
        {1'b1, 2'd1, 32'h0, 32'h0000_0100}) begin
      errors++;
      $display("FAIL timeout f=%b fc=%0d vel=%h pos=%h exp 1 1 0 00000100",
               fault, fault_code, velocity, position);
    end
    idle(5);
    checks++;
    if (fault_code !== 2'd1) begin
      errors++;
      $display("FAIL timeout_hold fc=%0d exp 1", fault_code);
    end
    tick(16'h0100, 1'b0, 1'b1, 1'b0);
    samp(16'h0180);
    checks++;
    if (position !== 32'h0000_0180 || valid !== 1'b1 ||
        fault_code !== 2'd0) begin
      errors++;
      $display("FAIL timeout_recover pos=%h v=%b fc=%0d exp 00000180 1 0",
               position, valid, fault_code);
    end
    idle(T);
    samp(16'h0200);
    idle(1);
    checks++;
    if (fault !== 1'b0 || valid !== 1'b1 ||
        position !== 32'h0000_0200) begin
      errors++;
      $display("FAIL expiry_sample f=%b v=%b pos=%h exp 0 1 00000200",
               fault, valid, position);
    end
  endtask

  task automatic test_velocity();
    logic [15:0] a;
    int v;
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    a = 16'h0000;
    samp(a);
    for (int i = 0; i < 40; i++) begin
      idle(99);
      a = a + 16'd100;
      samp(a);
      checks++;
      if (velocity !== m_vel_out()) begin
        errors++;
        $display("FAIL vel_fwd_model i=%0d got=%0d exp=%0d",
                 i, $signed(velocity), $signed(m_vel_out()));
      end
    end
    v = $signed(velocity);
    checks++;
    if (v < 1100 || v > 1300) begin
      errors++;
      $display("FAIL vel_fwd got=%0d exp 1200+-100", v);
    end
    for (int i = 0; i < 40; i++) begin
      idle(99);
      a = a - 16'd100;
      samp(a);
      checks++;
      if (velocity !== m_vel_out()) begin
        errors++;
        $display("FAIL vel_rev_model i=%0d got=%0d exp=%0d",
                 i, $signed(velocity), $signed(m_vel_out()));
      end
    end
    v = $signed(velocity);
    checks++;
    if (v > -1100 || v < -1300) begin
      errors++;
      $display("FAIL vel_rev got=%0d exp -1200+-100", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    a = 16'h0000;
    samp(a);
    for (int i = 0; i < 12; i++) begin
      idle(3);
      a = a + 16'h4000;
      samp(a);
    end
    checks++;
    if (position !== 32'h0003_0000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL multi_turn pos=%h v=%b exp 00030000 1",
               position, valid);
    end
    tick(a, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({position, velocity, valid, fault, fault_code} !== 68'h0) begin
      errors++;
      $display("FAIL reset_mid pos=%h vel=%h v=%b f=%b fc=%0d exp all 0",
               position, velocity, valid, fault, fault_code);
    end
    samp(16'h0005);
    checks++;
    if (position !== 32'h0000_0005 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_first pos=%h v=%b exp 00000005 1",
               position, valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        av;
    logic        fc;
    logic [67:0] got;
    logic [67:0] exp;
    int          gap;
    int          r;
    int          d;
    tick(16'h0, 1'b0, 1'b0, 1'b1);
    a = 16'($urandom);
    gap = 0;
    for (int i = 0; i < 6000; i++) begin
      av = 1'b0;
      fc = 1'b0;
      if (gap > 0) begin
        gap--;
      end else begin
        r = int'($urandom_range(0, 199));
        if (r < 25) begin
          av = 1'b1;
          if (r < 2)
            d = int'($urandom_range(0, 65535));
          else if (r < 6)
            d = (MS - 3 + int'($urandom_range(0, 6))) *
                (r[0] ? 1 : -1);
          else
            d = int'($urandom_range(0, 4000)) - 2000;
          a = a + 16'(d);
        end else if (r < 35) begin
          fc = 1'b1;
          av = r[0];
        end else if (r == 199) begin
          gap = T + int'($urandom_range(0, 4)) - 2;
        end
      end
      tick(a, av, fc, 1'b0);
      got = {position, velocity, valid, fault, fault_code};
      exp = {m_pos, m_vel_out(), (m_mode == 2),
             (m_mode == 3), m_fc};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random i=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_jump();
    test_timeout();
    test_velocity();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rioencoder_turns.md
# rioencoder_turns

Multi-turn tracker placed directly downstream of the single-turn UART absolute-encoder receiver. Consumes each accepted 16-bit angle sample (one full turn = 65536 counts) and unwraps it into a signed 32-bit multi-turn position. Also derives a windowed velocity, a link-loss watchdog and a jump-plausibility check. Outputs feed the joint feedback registers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 120000: clocks without a sample before a timeout fault (10 ms at 12 MHz).
- `MAX_STEP`, 16384: largest accepted per-sample movement magnitude in counts; legal range 1..32767.
- `VEL_PERIOD`, 12000: velocity window length in clocks; must be ≥ 2.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `angle`, in, 16: single-turn angle sample.
- `angle_valid`, in, 1: one-cycle strobe. `angle` is valid in the same cycle.
- `fault_clear`, in, 1: level or pulse. Acts only in FAULT.
- `position`, out, 32: signed multi-turn position.
- `velocity`, out, 32: signed count delta over the last window.
- `valid`, out, 1: high only in TRACK.
- `fault`, out, 1: high only in FAULT.
- `fault_code`, out, 2: 0 none, 1 timeout, 2 jump. Held until `fault_clear`.

## Operation
- Invariant in TRACK: `position[15:0]` equals the last accepted angle. No separate previous-angle register is kept.
- Per-sample delta: `d = angle - position[15:0]`, computed modulo 2^16 and interpreted as signed 16-bit (−32768..32767). It is sign-extended to 32 bits before being added to `position`. `position` wraps modulo 2^32 with no saturation.
- States:
  - INIT_RST: entered on reset. On `angle_valid`: `position <= {16'h0, angle}`, then go to TRACK.
  - TRACK: on `angle_valid`:
    - If `|d| ≤ MAX_STEP`: `position <= position + sext(d)`.
    - Otherwise: `position` is unchanged, `fault_code <= 2`, go to FAULT. A delta of −32768 is always a jump.
    - If the watchdog reaches `TIMEOUT_CYCLES` with no sample: `fault_code <= 1`, go to FAULT.
  - FAULT: `position` is held. On `fault_clear`: `fault_code <= 0`, go to INIT_RE.
  - INIT_RE: on `angle_valid`: `position <= position + sext(d)` with no `MAX_STEP` check, then go to TRACK. This re-anchors after a fault without losing the turn count.
- Watchdog: counter is cleared on every `angle_valid` and on any state change. It increments otherwise, saturating at `TIMEOUT_CYCLES`. It is evaluated only in TRACK. INIT states wait indefinitely.
- Velocity:
  - Window counter runs 0..VEL_PERIOD−1 and always free-runs.
  - At terminal count, in TRACK: `velocity <= position - snapshot`, `snapshot <= position`, using the current `position` register value.
  - Outside TRACK: `velocity` is forced to 0 and `snapshot` follows `position` every cycle, so the first TRACK window never spans a fault.
- Simultaneous events:
  - `angle_valid` and watchdog expiry in the same cycle: the sample wins and no timeout occurs.
  - `fault_clear` and `angle_valid` in FAULT: go to INIT_RE; that sample is ignored.
  - `fault_clear` outside FAULT: ignored.
  - Jump sample coinciding with velocity terminal count: velocity uses the pre-sample `position`.

## Timing
- Reset values: `position=0`, `velocity=0`, `valid=0`, `fault=0`, `fault_code=0`, state INIT_RST, all counters 0.
- `rst` mid-operation returns to INIT_RST on the next edge. The multi-turn count is discarded.
- `position` and state update on the edge after the `angle_valid` cycle, giving 1-clock latency.
- `valid`, `fault` and `fault_code` are registered and change together with the state.
- Timeout asserts `fault` exactly `TIMEOUT_CYCLES+1` clocks after the last sample strobe.
- `velocity` updates once per `VEL_PERIOD` clocks and holds between updates.

## Structure
- Package `rioencoder_turns_pkg`:
  - state enum (INIT_RST, INIT_RE, TRACK, FAULT)
  - fault-code constants (FC_NONE, FC_TIMEOUT, FC_JUMP)
  - the `sext16` helper
- Sub-module `rioencoder_turns_vel`: window counter, snapshot and subtractor. Inputs: `position`, `tracking`. Output: `velocity`.
- The top level holds the FSM, watchdog and unwrap adder.

## Test plan
- Reset, then angle 0x1234 → `position=0x00001234`, `valid=1`, one clock after the strobe.
- From 0xFFF0, sample 0x0010 → `position += 0x20`, giving 0x00010010. Sample 0xFFF0 again → back to 0x0000FFF0.
- From 0x1000, sample 0x6000 with `MAX_STEP=16384` → `fault=1`, `fault_code=2`, `position` held at 0x00001000. `fault_clear`, then sample 0x6000 → `position=0x00006000`, TRACK.
- No samples for `TIMEOUT_CYCLES` → `fault_code=1`, `velocity=0`. A sample landing on the expiry cycle instead → no fault.
- Samples +100 counts every 1000 clocks with `VEL_PERIOD=12000` → `velocity` settles at 1200 (±100 phase jitter). Negative direction → −1200.
- Assert `rst` mid-TRACK with `position=0x00030000` → all outputs 0 next clock. First sample 0x0005 → `position=5`.
